// File: rtl/svm_loader_pkg.sv
// Shared definitions for the SVM model loader: default widths, intercept sizing and controller states.
package svm_loader_pkg;

  localparam int unsigned NBITS_DEF     = 9;
  localparam int unsigned VSUP_DEF      = 120;
  localparam int unsigned ASUP_DEF      = 155;
  localparam int unsigned F_DEF         = 214;
  localparam int unsigned MEM_DEPTH_DEF = 214;
  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned LAT_W         = 16;

  // Intercept carries a full product plus accumulation headroom.
  function automatic int unsigned iw_for(input int unsigned nbits);
    return 2 * nbits + 8;
  endfunction

  localparam int unsigned IW_DEF = iw_for(NBITS_DEF);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    INTERCEPT,
    DONE,
    READY,
    SEND_V,
    SEND_A,
    WAIT_RES,
    HOLD_RES
  } state_e;

endpackage

// File: rtl/svm_loader.sv
// Loads SVM support rows and intercepts into the classifier, then sequences
// valence/arousal feature pairs through it and holds each result until taken.
module svm_loader
  import svm_loader_pkg::*;
#(
  parameter int unsigned NBITS      = NBITS_DEF,
  parameter int unsigned VSUP_WIDTH = VSUP_DEF,
  parameter int unsigned ASUP_WIDTH = ASUP_DEF,
  parameter int unsigned F_WIDTH    = F_DEF,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned IW         = iw_for(NBITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [IW-1:0]          cfg_v_intercept,
  input  logic signed [IW-1:0]          cfg_a_intercept,
  input  logic [NBITS*VSUP_WIDTH-1:0]   row_v_support,
  input  logic [NBITS-1:0]              row_v_alpha,
  input  logic [NBITS*ASUP_WIDTH-1:0]   row_a_support,
  input  logic [NBITS-1:0]              row_a_alpha,
  input  logic                          row_valid,
  output logic                          row_ready,
  output logic [NBITS*VSUP_WIDTH-1:0]   v_in_support,
  output logic [NBITS-1:0]              v_in_alpha,
  output logic [NBITS*ASUP_WIDTH-1:0]   a_in_support,
  output logic [NBITS-1:0]              a_in_alpha,
  output logic signed [IW-1:0]          v_in_intercept,
  output logic signed [IW-1:0]          a_in_intercept,
  output logic [ADDR_W-1:0]             mem_write_addr,
  output logic                          mem_we,
  input  logic                          mem_write_ready,
  output logic                          mem_write_done,
  output logic                          intercept_valid,
  input  logic [NBITS*F_WIDTH-1:0]      pair_v_features,
  input  logic [NBITS*F_WIDTH-1:0]      pair_a_features,
  input  logic                          pair_valid,
  output logic                          pair_ready,
  output logic [NBITS*F_WIDTH-1:0]      in_features,
  output logic                          fin_valid,
  input  logic                          fin_ready,
  input  logic                          valence,
  input  logic                          arousal,
  input  logic                          dout_valid,
  output logic                          dout_ready,
  output logic                          res_valence,
  output logic                          res_arousal,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [LAT_W-1:0]              res_latency,
  output logic                          loaded,
  output logic                          err_unexpected
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [LAT_W-1:0]           cnt_q, cnt_d;
  logic                       loaded_q, loaded_d;
  logic                       err_q, err_d;
  logic                       res_v_q, res_v_d;
  logic                       res_a_q, res_a_d;
  logic [LAT_W-1:0]           res_lat_q, res_lat_d;
  logic signed [IW-1:0]       v_int_q, v_int_d;
  logic signed [IW-1:0]       a_int_q, a_int_d;
  logic [NBITS*F_WIDTH-1:0]   v_feat_q, v_feat_d;
  logic [NBITS*F_WIDTH-1:0]   a_feat_q, a_feat_d;

  assign row_ready       = (state_q == LOAD) && mem_write_ready;
  assign mem_we          = row_valid && row_ready;
  assign v_in_support    = row_v_support;
  assign v_in_alpha      = row_v_alpha;
  assign a_in_support    = row_a_support;
  assign a_in_alpha      = row_a_alpha;
  assign v_in_intercept  = v_int_q;
  assign a_in_intercept  = a_int_q;
  assign mem_write_addr  = addr_q;
  assign intercept_valid = (state_q == INTERCEPT);
  assign mem_write_done  = (state_q == DONE);
  assign pair_ready      = (state_q == READY);
  assign fin_valid       = (state_q == SEND_V) || (state_q == SEND_A);
  assign in_features     = (state_q == SEND_A) ? a_feat_q : v_feat_q;
  assign dout_ready      = 1'b1;
  assign res_valid       = (state_q == HOLD_RES);
  assign res_valence     = res_v_q;
  assign res_arousal     = res_a_q;
  assign res_latency     = res_lat_q;
  assign loaded          = loaded_q;
  assign err_unexpected  = err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    loaded_d  = loaded_q;
    err_d     = err_q;
    res_v_d   = res_v_q;
    res_a_d   = res_a_q;
    res_lat_d = res_lat_q;
    v_int_d   = v_int_q;
    a_int_d   = a_int_q;
    v_feat_d  = v_feat_q;
    a_feat_d  = a_feat_q;

    // Latency runs from SEND_V entry through the result capture, saturating.
    if (((state_q == SEND_V) || (state_q == SEND_A) || (state_q == WAIT_RES)) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;

    if (dout_valid && (state_q != WAIT_RES))
      err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          v_int_d = cfg_v_intercept;
          a_int_d = cfg_a_intercept;
          addr_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (mem_we) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR)
            state_d = INTERCEPT;
        end
      end
      INTERCEPT: state_d = DONE;
      DONE: begin
        loaded_d = 1'b1;
        state_d  = READY;
      end
      READY: begin
        if (pair_valid) begin
          v_feat_d = pair_v_features;
          a_feat_d = pair_a_features;
          cnt_d    = '0;
          state_d  = SEND_V;
        end
      end
      SEND_V: begin
        if (fin_ready)
          state_d = SEND_A;
      end
      SEND_A: begin
        if (fin_ready)
          state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (dout_valid) begin
          res_v_d   = valence;
          res_a_d   = arousal;
          res_lat_d = cnt_q;
          state_d   = HOLD_RES;
        end
      end
      HOLD_RES: begin
        if (res_ready)
          state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
      res_v_q   <= 1'b0;
      res_a_q   <= 1'b0;
      res_lat_q <= '0;
      v_int_q   <= '0;
      a_int_q   <= '0;
      v_feat_q  <= '0;
      a_feat_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      loaded_q  <= loaded_d;
      err_q     <= err_d;
      res_v_q   <= res_v_d;
      res_a_q   <= res_a_d;
      res_lat_q <= res_lat_d;
      v_int_q   <= v_int_d;
      a_int_q   <= a_int_d;
      v_feat_q  <= v_feat_d;
      a_feat_q  <= a_feat_d;
    end
  end

endmodule

// File: tb/tb_svm_loader.sv
// Self-checking bench for svm_loader: load sequence, stalls, inference round trips and error/reset cases.
module tb_svm_loader;

  localparam int NB = 9;
  localparam int VS = 120;
  localparam int AS = 155;
  localparam int FW = 214;
  localparam int MD = 214;
  localparam int IW = 2 * NB + 8;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic signed [IW-1:0]    cfg_v_intercept, cfg_a_intercept;
  logic [NB*VS-1:0]        row_v_support;
  logic [NB-1:0]           row_v_alpha;
  logic [NB*AS-1:0]        row_a_support;
  logic [NB-1:0]           row_a_alpha;
  logic                    row_valid, row_ready;
  logic [NB*VS-1:0]        v_in_support;
  logic [NB-1:0]           v_in_alpha;
  logic [NB*AS-1:0]        a_in_support;
  logic [NB-1:0]           a_in_alpha;
  logic signed [IW-1:0]    v_in_intercept, a_in_intercept;
  logic [7:0]              mem_write_addr;
  logic                    mem_we, mem_write_ready, mem_write_done, intercept_valid;
  logic [NB*FW-1:0]        pair_v_features, pair_a_features, in_features;
  logic                    pair_valid, pair_ready, fin_valid, fin_ready;
  logic                    valence, arousal, dout_valid, dout_ready;
  logic                    res_valence, res_arousal, res_valid, res_ready;
  logic [15:0]             res_latency;
  logic                    loaded, err_unexpected;

  svm_loader #(
    .NBITS(NB), .VSUP_WIDTH(VS), .ASUP_WIDTH(AS), .F_WIDTH(FW), .MEM_DEPTH(MD), .IW(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_v_intercept(cfg_v_intercept), .cfg_a_intercept(cfg_a_intercept),
    .row_v_support(row_v_support), .row_v_alpha(row_v_alpha),
    .row_a_support(row_a_support), .row_a_alpha(row_a_alpha),
    .row_valid(row_valid), .row_ready(row_ready),
    .v_in_support(v_in_support), .v_in_alpha(v_in_alpha),
    .a_in_support(a_in_support), .a_in_alpha(a_in_alpha),
    .v_in_intercept(v_in_intercept), .a_in_intercept(a_in_intercept),
    .mem_write_addr(mem_write_addr), .mem_we(mem_we),
    .mem_write_ready(mem_write_ready), .mem_write_done(mem_write_done),
    .intercept_valid(intercept_valid),
    .pair_v_features(pair_v_features), .pair_a_features(pair_a_features),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .in_features(in_features), .fin_valid(fin_valid), .fin_ready(fin_ready),
    .valence(valence), .arousal(arousal), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .res_valence(res_valence), .res_arousal(res_arousal), .res_valid(res_valid),
    .res_ready(res_ready), .res_latency(res_latency),
    .loaded(loaded), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic       rv;
    logic       mwr;
    logic       exp_we;
    logic       exp_rr;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vt [7];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [NB*FW-1:0] act, input logic [NB*FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got low bits 0x%08h, want low bits 0x%08h (cycle %0d)", nm, act[31:0], exp[31:0], cyc);
    end
  endtask

  function automatic logic [NB*FW-1:0] rand_feat();
    logic [NB*FW-1:0] f;
    for (int i = 0; i < NB * FW; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic rand_rows();
    for (int i = 0; i < NB * VS; i++) row_v_support[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < NB * AS; i++) row_a_support[i] = 1'($urandom_range(0, 1));
    row_v_alpha = NB'($urandom);
    row_a_alpha = NB'($urandom);
  endtask

  // One pair through the classifier; latency L counts cycles from SEND_V entry to dout_valid.
  task automatic run_pair(input int L, input int stall, input int hold, input logic val, input logic aro);
    logic [NB*FW-1:0] vf, af;
    int sv_entry;
    vf = rand_feat();
    af = rand_feat();
    pair_v_features = vf;
    pair_a_features = af;
    pair_valid = 1'b1;
    fin_ready  = 1'b0;
    #1;
    chk("pair_ready_in_ready", pair_ready, 1);
    chk("fin_valid_idle", fin_valid, 0);
    tick();
    sv_entry = cyc;
    pair_valid = 1'b0;
    pair_v_features = ~vf;
    pair_a_features = ~af;
    for (int s = 0; s < stall; s++) begin
      #1;
      chk("fin_valid_stall", fin_valid, 1);
      chkw("in_features_v_stall", in_features, vf);
      tick();
    end
    fin_ready = 1'b1;
    #1;
    chk("fin_valid_v", fin_valid, 1);
    chkw("in_features_v", in_features, vf);
    tick();
    #1;
    chk("fin_valid_a", fin_valid, 1);
    chkw("in_features_a", in_features, af);
    tick();
    fin_ready = 1'b0;
    #1;
    chk("fin_valid_wait", fin_valid, 0);
    while (cyc - sv_entry < L) tick();
    dout_valid = 1'b1;
    valence = val;
    arousal = aro;
    tick();
    dout_valid = 1'b0;
    valence = ~val;
    arousal = ~aro;
    pair_valid = 1'b1;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("res_valid_hold", res_valid, 1);
      chk("res_valence_hold", res_valence, val);
      chk("res_arousal_hold", res_arousal, aro);
      chk("res_latency_hold", res_latency, (L > 65535) ? 65535 : L);
      chk("pair_ready_hold", pair_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("res_valid", res_valid, 1);
    chk("res_valence", res_valence, val);
    chk("res_arousal", res_arousal, aro);
    chk("res_latency", res_latency, (L > 65535) ? 65535 : L);
    tick();
    res_ready = 1'b0;
    pair_valid = 1'b0;
    #1;
    chk("res_valid_after_fire", res_valid, 0);
    chk("pair_ready_after_fire", pair_ready, 1);
    chk("no_pair_on_res_fire", fin_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [IW-1:0] lat_v, lat_a;
    int wr, guard, hold50;
    logic rv, mwr;

    rst = 1'b1; start = 1'b0; row_valid = 1'b1; mem_write_ready = 1'b1;
    cfg_v_intercept = '0; cfg_a_intercept = '0;
    row_v_support = '0; row_a_support = '0; row_v_alpha = '0; row_a_alpha = '0;
    pair_v_features = '0; pair_a_features = '0; pair_valid = 1'b0; fin_ready = 1'b0;
    valence = 1'b0; arousal = 1'b0; dout_valid = 1'b0; res_ready = 1'b0;

    vt[0] = '{rv: 1'b1, mwr: 1'b1, exp_we: 1'b1, exp_rr: 1'b1, exp_addr: 8'd0};
    vt[1] = '{rv: 1'b1, mwr: 1'b1, exp_we: 1'b1, exp_rr: 1'b1, exp_addr: 8'd1};
    vt[2] = '{rv: 1'b0, mwr: 1'b1, exp_we: 1'b0, exp_rr: 1'b1, exp_addr: 8'd2};
    vt[3] = '{rv: 1'b1, mwr: 1'b0, exp_we: 1'b0, exp_rr: 1'b0, exp_addr: 8'd2};
    vt[4] = '{rv: 1'b0, mwr: 1'b0, exp_we: 1'b0, exp_rr: 1'b0, exp_addr: 8'd2};
    vt[5] = '{rv: 1'b1, mwr: 1'b1, exp_we: 1'b1, exp_rr: 1'b1, exp_addr: 8'd2};
    vt[6] = '{rv: 1'b1, mwr: 1'b1, exp_we: 1'b1, exp_rr: 1'b1, exp_addr: 8'd3};

    // Reset state
    tick();
    tick();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_intercept_valid", intercept_valid, 0);
    chk("rst_mem_write_done", mem_write_done, 0);
    chk("rst_fin_valid", fin_valid, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_latency", res_latency, 0);
    chk("rst_addr", mem_write_addr, 0);
    chk("rst_row_ready", row_ready, 0);
    chk("dout_ready", dout_ready, 1);
    rst = 1'b0;
    row_valid = 1'b0;

    lat_v = IW'($urandom);
    lat_a = IW'($urandom);
    cfg_v_intercept = lat_v;
    cfg_a_intercept = lat_a;
    start = 1'b1;
    tick();
    start = 1'b0;

    // Table-driven start of load, with a start pulse mid-load that must be ignored
    for (int i = 0; i < 7; i++) begin
      row_valid = vt[i].rv;
      mem_write_ready = vt[i].mwr;
      start = (i == 2);
      cfg_v_intercept = (i == 2) ? ~lat_v : lat_v;
      cfg_a_intercept = (i == 2) ? ~lat_a : lat_a;
      rand_rows();
      #1;
      chk("tbl_mem_we", mem_we, vt[i].exp_we);
      chk("tbl_row_ready", row_ready, vt[i].exp_rr);
      chk("tbl_addr", mem_write_addr, vt[i].exp_addr);
      chk("tbl_v_alpha_pass", v_in_alpha, row_v_alpha);
      chk("tbl_a_support_pass", a_in_support[63:0], row_a_support[63:0]);
      tick();
    end
    start = 1'b0;

    // Randomized remainder of the load; address model is the count of accepted writes
    wr = 4;
    guard = 0;
    hold50 = 0;
    while (wr < MD && guard < 3000) begin
      rv  = ($urandom_range(0, 4) != 0);
      mwr = ($urandom_range(0, 5) != 0);
      if (wr == 50 && hold50 < 3) begin
        rv = 1'b0;
        mwr = 1'b1;
        hold50++;
      end
      row_valid = rv;
      mem_write_ready = mwr;
      rand_rows();
      #1;
      chk("load_addr", mem_write_addr, wr);
      chk("load_mem_we", mem_we, rv && mwr);
      chk("load_no_intercept", intercept_valid, 0);
      chk("load_no_done", mem_write_done, 0);
      if (rv && mwr) wr++;
      tick();
      guard++;
    end
    chk("load_completed", wr, MD);
    row_valid = 1'b0;
    #1;
    chk("intercept_valid", intercept_valid, 1);
    chk("v_intercept", v_in_intercept, lat_v);
    chk("a_intercept", a_in_intercept, lat_a);
    chk("intercept_no_we", mem_we, 0);
    chk("intercept_not_loaded", loaded, 0);
    tick();
    chk("intercept_one_cycle", intercept_valid, 0);
    chk("mem_write_done", mem_write_done, 1);
    tick();
    chk("done_one_cycle", mem_write_done, 0);
    chk("loaded", loaded, 1);
    chk("ready_pair_ready", pair_ready, 1);
    chk("ready_row_ready", row_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("start_ignored_ready", pair_ready, 1);
    chk("start_ignored_loaded", loaded, 1);

    // Directed round trip: latency 20, valence=1 arousal=0, result held 10 cycles
    run_pair(20, 0, 10, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      int st;
      st = $urandom_range(0, 3);
      run_pair($urandom_range(st + 2, st + 40), st, $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("no_err_normal", err_unexpected, 0);
    chk("loaded_sticky", loaded, 1);

    // Unexpected dout_valid while READY
    dout_valid = 1'b1;
    valence = 1'b1;
    arousal = 1'b1;
    tick();
    dout_valid = 1'b0;
    #1;
    chk("err_set", err_unexpected, 1);
    chk("err_no_res", res_valid, 0);
    chk("err_still_ready", pair_ready, 1);
    tick();
    tick();
    chk("err_sticky", err_unexpected, 1);

    // Reset mid-load at address 100
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    row_valid = 1'b1;
    mem_write_ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    #1;
    chk("pre_rst_addr", mem_write_addr, 100);
    chk("pre_rst_we", mem_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_addr", mem_write_addr, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_loaded", loaded, 0);
    chk("midrst_row_ready", row_ready, 0);
    chk("midrst_err", err_unexpected, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("restart_row_ready", row_ready, 1);
    chk("restart_addr", mem_write_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
